regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: the ALU result path and the memory-load result path.
- Each requester has a 1-entry holding register with a valid/ready handshake.
- A round-robin arbiter moves one held request per cycle into a registered write-port stage.
- Exports a per-register pending-write bitmap so the decode stage can stall on RAW hazards against not-yet-written destinations.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, width of destination register index
NREGS, 32, number of architectural registers; must equal 2**ADDR_W

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU writeback request present
alu_ready  output  1  ALU holding register can accept this cycle
alu_dst  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load writeback request present
mem_ready  output  1  load holding register can accept this cycle
mem_dst  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
wr_en  output  1  register-file write enable, registered
wr_addr  output  ADDR_W  register-file write index, registered
wr_data  output  DATA_W  register-file write data, registered
busy  output  NREGS  bit r is high while any accepted, not-yet-retired write targets r
conflict  output  1  registered; high for one cycle after any cycle where both holds were valid

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - Both hold valids cleared.
  - wr_en=0, wr_addr=0, wr_data=0.
  - rr_ptr=0 (ALU favoured).
  - conflict=0.
  - busy=0 follows combinationally.
  - Requests held when reset asserts are discarded, not written.
- Hold state per requester (x in {alu, mem}): hold_v_x, hold_dst_x, hold_data_x.
- Ready is combinational from state only, never from the x_valid inputs: x_ready = !hold_v_x || grant_x.
- Accept: x_valid && x_ready at a rising edge loads the hold with dst/data and sets hold_v_x. This permits one accept per cycle per requester, back-to-back.
- Grant (combinational):
  - Both holds valid: the favoured one wins. rr_ptr=0 favours ALU; rr_ptr=1 favours MEM.
  - Only one hold valid: that one wins.
  - Neither valid: no grant.
- On a grant edge:
  - wr_en<=1, wr_addr/wr_data <= the winner's hold.
  - The winner's hold_v is cleared unless it is reloaded in the same edge.
  - rr_ptr <= the non-winner index.
- No grant: wr_en<=0; wr_addr/wr_data hold their previous values.
- Latency: a request accepted at edge E0 drives wr_en high in the cycle after E1 at the earliest. The register file writes at edge E2. A loser waits exactly one extra cycle, because the next cycle the round-robin favours it.
- Throughput: one write per cycle. Sustained dual traffic alternates ALU, MEM, ALU, ...
- busy[r] = (hold_v_alu && hold_dst_alu==r) | (hold_v_mem && hold_dst_mem==r) | (wr_en && wr_addr==r). This is combinational from registered state. Register 0 is a normal writable register with no special casing.
- Same destination in both holds: both writes occur in grant order. The later write wins in the register file. busy stays high until the second write retires.
- conflict <= hold_v_alu && hold_v_mem each cycle.
- Reset mid-operation: pending holds and the output stage are dropped; wr_en falls immediately (asynchronously).

Test Plan:
- Reset: assert rst with both holds loaded -> wr_en=0, busy=0, alu_ready=mem_ready=1 immediately; after release, first single request grants normally.
- Single ALU request: alu_valid=1, dst=7, data=0x0000002A for 1 cycle -> busy[7]=1 from the next cycle; wr_en=1, wr_addr=7, wr_data=0x2A one cycle later; busy[7]=0 after that write cycle.
- Simultaneous, rr_ptr=0: alu dst=3 data=0x11 and mem dst=4 data=0x22 in the same cycle -> wr cycle 1 writes reg 3 =0x11, wr cycle 2 writes reg 4 =0x22; conflict pulses once; mem_ready=0 for exactly 1 cycle.
- Sustained dual streams of 8 requests each -> writes strictly alternate ALU/MEM starting with ALU; 16 writes in 16 consecutive cycles; no request lost or duplicated.
- Same destination: alu dst=5 data=0xAA and mem dst=5 data=0xBB together -> two writes in order 0xAA then 0xBB; busy[5] high continuously until the 0xBB write retires.
- Back-to-back MEM only: mem_valid held high for 4 cycles, dst=1..4 -> mem_ready stays 1 throughout; writes to regs 1, 2, 3, 4 on consecutive cycles; rr_ptr ends at 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester and register-file write-port bundle
//
// Purpose: groups the two writeback request channels (ALU, MEM), the
// registered register-file write port and the hazard outputs into one bundle.
// Ports:
//   alu_valid/alu_ready/alu_dst/alu_data : ALU writeback request channel
//   mem_valid/mem_ready/mem_dst/mem_data : load writeback request channel
//   wr_en/wr_addr/wr_data                : registered register-file write port
//   busy                                 : per-register pending-write bitmap
//   conflict                             : one-cycle pulse after both holds were valid
// Modports: master drives requests (pipeline side); slave is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_dst;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_dst;
  logic [DATA_W-1:0] mem_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREGS-1:0]  busy;
  logic              conflict;

  modport master (
    output alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data,
    input  alu_ready, mem_ready, wr_en, wr_addr, wr_data, busy, conflict
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data,
    output alu_ready, mem_ready, wr_en, wr_addr, wr_data, busy, conflict
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin sharing of the register-file write port
//
// Purpose: each of the ALU and load writeback paths owns a 1-entry holding
// register; a round-robin arbiter moves one held request per cycle into a
// registered write-port stage and a pending-write bitmap is exported for
// RAW-hazard stalls in decode.
// Ports:
//   clk : system clock, all state on rising edge
//   rst : asynchronous, active-high reset
//   bus : regfile_wb_arbiter_if.slave (request channels, write port, busy, conflict)
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus
);

  logic              hold_v_alu;
  logic [ADDR_W-1:0] hold_dst_alu;
  logic [DATA_W-1:0] hold_data_alu;
  logic              hold_v_mem;
  logic [ADDR_W-1:0] hold_dst_mem;
  logic [DATA_W-1:0] hold_data_mem;

  logic              rr_ptr;   // 0: ALU favoured, 1: MEM favoured
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              conflict;

  logic              grant_alu;
  logic              grant_mem;
  logic              accept_alu;
  logic              accept_mem;
  logic [NREGS-1:0]  busy;

  // The favoured side only matters when both holds are occupied.
  assign grant_alu = hold_v_alu && (!hold_v_mem || !rr_ptr);
  assign grant_mem = hold_v_mem && (!hold_v_alu ||  rr_ptr);

  // Ready depends on state only, so a hold being drained this cycle can
  // refill in the same edge without a bubble.
  assign bus.alu_ready = !hold_v_alu || grant_alu;
  assign bus.mem_ready = !hold_v_mem || grant_mem;

  assign accept_alu = bus.alu_valid && bus.alu_ready;
  assign accept_mem = bus.mem_valid && bus.mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v_alu    <= 1'b0;
      hold_dst_alu  <= '0;
      hold_data_alu <= '0;
    end else if (accept_alu) begin
      hold_v_alu    <= 1'b1;
      hold_dst_alu  <= bus.alu_dst;
      hold_data_alu <= bus.alu_data;
    end else if (grant_alu) begin
      hold_v_alu    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v_mem    <= 1'b0;
      hold_dst_mem  <= '0;
      hold_data_mem <= '0;
    end else if (accept_mem) begin
      hold_v_mem    <= 1'b1;
      hold_dst_mem  <= bus.mem_dst;
      hold_data_mem <= bus.mem_data;
    end else if (grant_mem) begin
      hold_v_mem    <= 1'b0;
    end
  end

  // Write-port stage; the pointer always moves to the side that did not win,
  // including when only one side was requesting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rr_ptr  <= 1'b0;
    end else if (grant_alu) begin
      wr_en   <= 1'b1;
      wr_addr <= hold_dst_alu;
      wr_data <= hold_data_alu;
      rr_ptr  <= 1'b1;
    end else if (grant_mem) begin
      wr_en   <= 1'b1;
      wr_addr <= hold_dst_mem;
      wr_data <= hold_data_mem;
      rr_ptr  <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict <= 1'b0;
    end else begin
      conflict <= hold_v_alu && hold_v_mem;
    end
  end

  // A destination stays busy from acceptance until its write-port cycle ends;
  // register 0 is treated like any other register.
  always_comb begin
    busy = '0;
    if (hold_v_alu) busy[hold_dst_alu] = 1'b1;
    if (hold_v_mem) busy[hold_dst_mem] = 1'b1;
    if (wr_en)      busy[wr_addr]      = 1'b1;
  end

  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;
  assign bus.busy     = busy;
  assign bus.conflict = conflict;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) bus ();

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] dst, input logic [31:0] data);
    bus.alu_valid = 1'b1;
    bus.alu_dst   = dst;
    bus.alu_data  = data;
  endtask

  task automatic drive_mem(input logic [4:0] dst, input logic [31:0] data);
    bus.mem_valid = 1'b1;
    bus.mem_dst   = dst;
    bus.mem_data  = data;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int an, mn, wn, first, last;
    logic ar, mr, av, mv;
    logic [31:0] exp_addr, exp_data;

    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_dst = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_dst = '0; bus.mem_data = '0;
    #12;
    check("rst_wr_en",     bus.wr_en, 0);
    check("rst_wr_addr",   bus.wr_addr, 0);
    check("rst_wr_data",   bus.wr_data, 0);
    check("rst_busy",      bus.busy, 0);
    check("rst_conflict",  bus.conflict, 0);
    check("rst_alu_ready", bus.alu_ready, 1);
    check("rst_mem_ready", bus.mem_ready, 1);
    rst = 1'b0;
    tick;

    // Single ALU request
    drive_alu(5'd7, 32'h0000002A);
    tick;
    idle;
    check("single_busy_hold", bus.busy, 64'h80);
    check("single_wr_en_early", bus.wr_en, 0);
    tick;
    check("single_wr_en",   bus.wr_en, 1);
    check("single_wr_addr", bus.wr_addr, 7);
    check("single_wr_data", bus.wr_data, 32'h2A);
    check("single_busy_wr", bus.busy, 64'h80);
    tick;
    check("single_wr_en_off", bus.wr_en, 0);
    check("single_busy_clr",  bus.busy, 0);
    check("single_data_kept", bus.wr_data, 32'h2A);

    // Pointer now favours MEM after the ALU-only grant
    drive_alu(5'd9, 32'h99);
    drive_mem(5'd10, 32'hA0);
    tick;
    idle;
    tick;
    check("rr1_first_addr", bus.wr_addr, 10);
    check("rr1_first_data", bus.wr_data, 32'hA0);
    tick;
    check("rr1_second_addr", bus.wr_addr, 9);
    check("rr1_second_data", bus.wr_data, 32'h99);
    tick;
    check("rr1_drained", bus.wr_en, 0);

    // Simultaneous requests from reset state (ALU favoured)
    do_reset;
    tick;
    drive_alu(5'd3, 32'h11);
    drive_mem(5'd4, 32'h22);
    tick;
    idle;
    check("sim_mem_ready_low", bus.mem_ready, 0);
    check("sim_alu_ready",     bus.alu_ready, 1);
    check("sim_conflict_pre",  bus.conflict, 0);
    check("sim_busy",          bus.busy, 64'h18);
    tick;
    check("sim_w1_en",    bus.wr_en, 1);
    check("sim_w1_addr",  bus.wr_addr, 3);
    check("sim_w1_data",  bus.wr_data, 32'h11);
    check("sim_conflict", bus.conflict, 1);
    check("sim_mem_ready_back", bus.mem_ready, 1);
    tick;
    check("sim_w2_en",    bus.wr_en, 1);
    check("sim_w2_addr",  bus.wr_addr, 4);
    check("sim_w2_data",  bus.wr_data, 32'h22);
    check("sim_conflict_off", bus.conflict, 0);
    tick;
    check("sim_drained", bus.wr_en, 0);
    check("sim_busy_clr", bus.busy, 0);

    // Sustained dual streams: ALU dst i data 0x100+i, MEM dst 16+i data 0x200+i
    an = 0; mn = 0; wn = 0; first = -1; last = -1;
    drive_alu(5'd0, 32'h100);
    drive_mem(5'd16, 32'h200);
    for (int cyc = 0; cyc < 40 && wn < 16; cyc++) begin
      ar = bus.alu_ready; mr = bus.mem_ready;
      av = bus.alu_valid; mv = bus.mem_valid;
      tick;
      if (av && ar) an++;
      if (mv && mr) mn++;
      bus.alu_valid = (an < 8);
      bus.alu_dst   = an[4:0];
      bus.alu_data  = 32'h100 + an;
      bus.mem_valid = (mn < 8);
      bus.mem_dst   = 5'd16 + mn[4:0];
      bus.mem_data  = 32'h200 + mn;
      if (bus.wr_en) begin
        exp_addr = (wn % 2 == 0) ? wn / 2 : 16 + wn / 2;
        exp_data = (wn % 2 == 0) ? 32'h100 + wn / 2 : 32'h200 + wn / 2;
        check("stream_addr", bus.wr_addr, exp_addr);
        check("stream_data", bus.wr_data, exp_data);
        if (first < 0) first = cyc;
        last = cyc;
        wn++;
      end
    end
    idle;
    check("stream_count", wn, 16);
    check("stream_span", last - first + 1, 16);
    tick;
    check("stream_drained", bus.wr_en, 0);
    check("stream_busy_clr", bus.busy, 0);

    // Same destination from both sides
    drive_alu(5'd5, 32'hAA);
    drive_mem(5'd5, 32'hBB);
    tick;
    idle;
    check("same_busy0", bus.busy, 64'h20);
    tick;
    check("same_w1_data", bus.wr_data, 32'hAA);
    check("same_w1_addr", bus.wr_addr, 5);
    check("same_busy1",   bus.busy, 64'h20);
    tick;
    check("same_w2_data", bus.wr_data, 32'hBB);
    check("same_w2_en",   bus.wr_en, 1);
    check("same_busy2",   bus.busy, 64'h20);
    tick;
    check("same_busy_clr", bus.busy, 0);
    check("same_drained",  bus.wr_en, 0);

    // Back-to-back MEM only, dst 1..4
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) drive_mem(i[4:0], 32'h30 + i);
      else        idle;
      check("memonly_ready", bus.mem_ready, 1);
      tick;
      if (i >= 2) begin
        check("memonly_en",   bus.wr_en, 1);
        check("memonly_addr", bus.wr_addr, i - 1);
        check("memonly_data", bus.wr_data, 32'h30 + i - 1);
      end
    end
    // Pointer must be back on ALU after a MEM-only run
    drive_alu(5'd20, 32'hC0);
    drive_mem(5'd21, 32'hC1);
    tick;
    idle;
    tick;
    check("rr0_first_addr", bus.wr_addr, 20);
    tick;
    check("rr0_second_addr", bus.wr_addr, 21);
    tick;

    // Reset mid-operation with a write in flight and a hold pending
    drive_alu(5'd12, 32'hD0);
    drive_mem(5'd13, 32'hD1);
    tick;
    idle;
    tick;
    check("mid_wr_en_before", bus.wr_en, 1);
    #3;
    rst = 1'b1;
    #1;
    check("mid_wr_en",     bus.wr_en, 0);
    check("mid_wr_addr",   bus.wr_addr, 0);
    check("mid_wr_data",   bus.wr_data, 0);
    check("mid_busy",      bus.busy, 0);
    check("mid_alu_ready", bus.alu_ready, 1);
    check("mid_mem_ready", bus.mem_ready, 1);
    check("mid_conflict",  bus.conflict, 0);
    #1;
    rst = 1'b0;
    tick;
    check("mid_discarded", bus.wr_en, 0);
    drive_mem(5'd2, 32'h55);
    tick;
    idle;
    tick;
    check("post_rst_en",   bus.wr_en, 1);
    check("post_rst_addr", bus.wr_addr, 2);
    check("post_rst_data", bus.wr_data, 32'h55);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
